// File: rtl/project2_pkg.sv
// Shared constants for the project2 BCD up/down counter: default tick divisor
// and active-low seven-segment codes (bit0..6 = a..g, bit7 = decimal point).
package project2_pkg;

  localparam int TICK_DIV_DEFAULT = 10_000_000;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  // All segments and the decimal point dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/project2_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern, purely combinational;
// non-BCD codes blank the digit.
module seg7_decoder
  import project2_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/project2.sv
// Six-digit BCD up/down counter stepping once per TICK_DIV clocks; count updates
// on the tick edge, displays decode combinationally, KEY[1] low pauses everything.
module project2
  import project2_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       ADC_CLK_10,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [9:0] LEDR
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic             rst;
  logic             run;
  logic             down;
  logic             tick;
  logic [DIV_W-1:0] div;
  logic [3:0]       digit     [6];
  logic [3:0]       nxt_digit [6];
  logic             carry;
  logic             unused_sw;

  assign rst       = ~KEY[0];
  assign run       = KEY[1];
  assign down      = SW[9];
  assign tick      = run && (div == DIV_LAST);
  assign unused_sw = ^SW[8:0];

  // Ripple the +1/-1 through the digits; a digit only moves while every lower
  // digit is wrapping, which gives 999999<->000000 wrap for free.
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt_digit[i] = digit[i];
      if (carry) begin
        if (!down) begin
          if (digit[i] == 4'd9) begin
            nxt_digit[i] = 4'd0;
          end else begin
            nxt_digit[i] = digit[i] + 4'd1;
            carry        = 1'b0;
          end
        end else begin
          if (digit[i] == 4'd0) begin
            nxt_digit[i] = 4'd9;
          end else begin
            nxt_digit[i] = digit[i] - 4'd1;
            carry        = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (rst) begin
      div   <= '0;
      digit <= '{default: 4'd0};
    end else if (run) begin
      if (tick) begin
        div   <= '0;
        digit <= nxt_digit;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  seg7_decoder u_dec0 (.bcd(digit[0]), .seg(HEX0));
  seg7_decoder u_dec1 (.bcd(digit[1]), .seg(HEX1));
  seg7_decoder u_dec2 (.bcd(digit[2]), .seg(HEX2));
  seg7_decoder u_dec3 (.bcd(digit[3]), .seg(HEX3));
  seg7_decoder u_dec4 (.bcd(digit[4]), .seg(HEX4));
  seg7_decoder u_dec5 (.bcd(digit[5]), .seg(HEX5));

  assign LEDR = {SW[9], KEY[1], digit[1], digit[0]};

endmodule

// File: tb/tb_project2.sv
// Bench for project2: directed scenarios plus randomized keys/switches, every
// cycle compared against an integer-count reference model.
module tb_project2;

  localparam int TICK = 10;

  logic       clk;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int n_tests = 0;
  int n_fail  = 0;

  int model_cnt   = 0;
  int model_phase = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  project2 #(.TICK_DIV(TICK)) dut (
    .ADC_CLK_10(clk),
    .KEY(KEY),
    .SW(SW),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3),
    .HEX4(HEX4),
    .HEX5(HEX5),
    .LEDR(LEDR)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int dig(input int c, input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return (c / p) % 10;
  endfunction

  // Reference behaviour: one clock edge applied to an integer count.
  task automatic model_step();
    if (!KEY[0]) begin
      model_cnt   = 0;
      model_phase = 0;
    end else if (KEY[1]) begin
      model_phase++;
      if (model_phase == TICK) begin
        model_phase = 0;
        model_cnt   = SW[9] ? (model_cnt + 999_999) % 1_000_000
                            : (model_cnt + 1) % 1_000_000;
      end
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic [63:0] v;
    v = '0;
    for (int n = 0; n < 6; n++) v[10 + 8*n +: 8] = seg_tab[dig(model_cnt, n)];
    v[9]   = SW[9];
    v[8]   = KEY[1];
    v[7:4] = 4'(dig(model_cnt, 1));
    v[3:0] = 4'(dig(model_cnt, 0));
    return v;
  endfunction

  function automatic logic [63:0] got_vec();
    return {6'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDR};
  endfunction

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", got_vec(), exp_vec());
    end
  endtask

  initial begin
    KEY = 2'b10;
    SW  = 10'd0;

    // Reset held for 100 ns.
    cycle(5);
    check("rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{8'hC0}});
    check("rst_ledr", LEDR[7:0], 8'h00);

    KEY[0] = 1'b1;
    cycle(TICK - 1);
    check("pre_first_tick", LEDR[7:0], 8'h00);
    cycle(1);
    check("first_tick", LEDR[7:0], 8'h01);

    cycle(1000 - TICK);
    check("c100_hex2", HEX2, 8'hF9);
    check("c100_hex1", HEX1, 8'hC0);
    check("c100_hex0", HEX0, 8'hC0);
    check("c100_ledr", LEDR[7:0], 8'h00);

    SW[9] = 1'b1;
    cycle(200);
    check("c080_ledr", LEDR[7:0], 8'h80);
    check("c080_dir", LEDR[9], 1'b1);
    check("c080_hex2", HEX2, 8'hC0);

    cycle(80 * TICK);
    check("c000", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{8'hC0}});
    cycle(TICK);
    check("wrap_down", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{8'h90}});
    SW[9] = 1'b0;
    cycle(TICK);
    check("wrap_up", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{8'hC0}});

    // Pause with divider at phase 3.
    cycle(3);
    KEY[1] = 1'b0;
    cycle(50);
    check("pause_led", LEDR[8], 1'b0);
    check("pause_cnt", LEDR[7:0], 8'h00);
    KEY[1] = 1'b1;
    cycle(TICK - 4);
    check("resume_early", LEDR[7:0], 8'h00);
    cycle(1);
    check("resume_tick", LEDR[7:0], 8'h01);

    // Reset on the cycle a tick is due.
    cycle(TICK - 1);
    check("due_before", LEDR[7:0], 8'h01);
    KEY[0] = 1'b0;
    cycle(1);
    check("due_rst", LEDR[7:0], 8'h00);
    KEY[0] = 1'b1;
    cycle(TICK - 1);
    check("rst_full_interval", LEDR[7:0], 8'h00);
    cycle(1);
    check("rst_first_tick", LEDR[7:0], 8'h01);

    // Randomized keys and switches.
    for (int r = 0; r < 3000; r++) begin
      KEY[0]  = ($urandom_range(0, 199) != 0);
      KEY[1]  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) SW[9] = ~SW[9];
      SW[8:0] = 9'($urandom);
      cycle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
